// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath: address-generator state
// encoding, a width helper and the default layer dimensions used by the
// control unit, the address generator and the ALU.
package nn_pkg;

  typedef enum logic [1:0] {
    AG_IDLE = 2'd0,
    AG_RUN  = 2'd1,
    AG_DONE = 2'd2
  } ag_state_e;

  localparam int DEF_N_INPUTS  = 32'sd4;
  localparam int DEF_N_NEURONS = 32'sd3;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int bits;
    int one;
    bits = 32'sd0;
    one  = 32'sd1;
    for (int i = 32'sd0; i < 32'sd31; i++) begin
      if ((one << i) < value) begin
        bits = i + 32'sd1;
      end else begin
        bits = bits;
      end
    end
    return (bits < 32'sd1) ? 32'sd1 : bits;
  endfunction

endpackage

// File: rtl/nn_address_generator_if.sv
// Address bus between the address generator (master) and the MAC/ALU (slave).
// The generator presents an address with addr_valid; the ALU takes it when
// alu_ready is high in the same cycle.
interface nn_address_generator_if #(
  parameter int IN_W = 32'sd2,
  parameter int N_W  = 32'sd2,
  parameter int WA_W = 32'sd4
) ();

  logic            addr_valid;
  logic            alu_ready;
  logic [IN_W-1:0] in_addr;
  logic [WA_W-1:0] w_addr;
  logic [N_W-1:0]  neuron_idx;
  logic            first_term;
  logic            last_term;

  modport master (
    output addr_valid,
    output in_addr,
    output w_addr,
    output neuron_idx,
    output first_term,
    output last_term,
    input  alu_ready
  );

  modport slave (
    input  addr_valid,
    input  in_addr,
    input  w_addr,
    input  neuron_idx,
    input  first_term,
    input  last_term,
    output alu_ready
  );

endinterface

// File: rtl/nn_wrap_counter.sv
// Registered up-counter with enable, synchronous clear and wrap at MAX.
// tc flags that the current count equals MAX, so the next enabled step wraps.
module nn_wrap_counter #(
  parameter int               WIDTH = 32'sd2,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear has priority, then wrap-or-increment when enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == MAX) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1'b1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == MAX);

endmodule

// File: rtl/nn_address_generator.sv
// Address generator for a fully-connected layer. Walks every input of every
// neuron, presenting the input-vector address and the matching weight address
// to the ALU under a valid/ready handshake, tagging the first and last term of
// each neuron and pulsing layer_done once the final address is taken.
module nn_address_generator
  import nn_pkg::*;
#(
  parameter int N_INPUTS  = DEF_N_INPUTS,
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int IN_W      = clog2_min1(N_INPUTS),
  parameter int N_W       = clog2_min1(N_NEURONS),
  parameter int WA_W      = clog2_min1(N_INPUTS * N_NEURONS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  AG_rst,
  input  logic                  AG_read,
  nn_address_generator_if.master alu_if,
  output logic                  layer_done,
  output logic                  busy
);

  localparam logic [IN_W-1:0] IN_FIRST  = '0;
  localparam logic [IN_W-1:0] IN_LAST   = IN_W'(N_INPUTS - 32'sd1);
  localparam logic [IN_W-1:0] IN_PENULT = IN_W'(N_INPUTS - 32'sd2);
  localparam logic [N_W-1:0]  N_LAST    = N_W'(N_NEURONS - 32'sd1);

  ag_state_e       state_q;
  ag_state_e       state_d;

  logic            addr_valid_q;
  logic            addr_valid_d;
  logic            first_term_q;
  logic            first_term_d;
  logic            last_term_q;
  logic            last_term_d;
  logic            layer_done_q;
  logic            layer_done_d;
  logic            busy_q;
  logic            busy_d;
  logic [WA_W-1:0] w_addr_q;
  logic [WA_W-1:0] w_addr_d;

  logic [IN_W-1:0] in_addr_s;
  logic [N_W-1:0]  neuron_idx_s;
  logic            in_tc_s;
  logic            n_tc_s;
  logic            transfer_s;
  logic            neuron_en_s;
  logic            last_xfer_s;
  logic            in_first_nxt_s;
  logic            in_last_nxt_s;

  // A transfer only happens while an address is on offer, so it is implicitly
  // confined to RUN; AG_rst overrides it inside every consumer.
  assign transfer_s  = addr_valid_q & alu_if.alu_ready;
  assign neuron_en_s = transfer_s & in_tc_s;
  assign last_xfer_s = transfer_s & in_tc_s & n_tc_s;

  nn_wrap_counter #(
    .WIDTH (IN_W),
    .MAX   (IN_LAST)
  ) u_in_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (AG_rst),
    .en    (transfer_s),
    .count (in_addr_s),
    .tc    (in_tc_s)
  );

  nn_wrap_counter #(
    .WIDTH (N_W),
    .MAX   (N_LAST)
  ) u_neuron_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (AG_rst),
    .en    (neuron_en_s),
    .count (neuron_idx_s),
    .tc    (n_tc_s)
  );

  // Term flags for the address that will be held after this edge, so they
  // are registered in step with the counter they describe.
  assign in_first_nxt_s = AG_rst | (transfer_s ? in_tc_s : (in_addr_s == IN_FIRST));
  assign in_last_nxt_s  = ~AG_rst & (transfer_s ? (in_addr_s == IN_PENULT) : in_tc_s);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= AG_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: AG_rst abandons any layer, DONE is sticky until cleared.
  always_comb begin
    state_d = state_q;
    if (AG_rst) begin
      state_d = AG_IDLE;
    end else begin
      case (state_q)
        AG_IDLE: begin
          if (AG_read) begin
            state_d = AG_RUN;
          end else begin
            state_d = AG_IDLE;
          end
        end
        AG_RUN: begin
          if (last_xfer_s) begin
            state_d = AG_DONE;
          end else begin
            state_d = AG_RUN;
          end
        end
        AG_DONE: begin
          state_d = AG_DONE;
        end
        default: begin
          state_d = AG_IDLE;
        end
      endcase
    end
  end

  // Output decode for the next cycle; everything visible is registered.
  always_comb begin
    addr_valid_d = 1'b0;
    busy_d       = 1'b0;
    layer_done_d = 1'b0;
    first_term_d = 1'b0;
    last_term_d  = 1'b0;
    if (state_d == AG_RUN) begin
      addr_valid_d = AG_read;
      busy_d       = 1'b1;
      first_term_d = in_first_nxt_s;
      last_term_d  = in_last_nxt_s;
    end else begin
      addr_valid_d = 1'b0;
      busy_d       = 1'b0;
      first_term_d = 1'b0;
      last_term_d  = 1'b0;
    end
    if ((state_q == AG_RUN) && (state_d == AG_DONE)) begin
      layer_done_d = 1'b1;
    end else begin
      layer_done_d = 1'b0;
    end
  end

  // Weight address runs as a plain incrementer alongside the two counters and
  // wraps to zero with them after the final term.
  always_comb begin
    w_addr_d = w_addr_q;
    if (AG_rst) begin
      w_addr_d = '0;
    end else if (transfer_s) begin
      if (last_xfer_s) begin
        w_addr_d = '0;
      end else begin
        w_addr_d = w_addr_q + WA_W'(1'b1);
      end
    end else begin
      w_addr_d = w_addr_q;
    end
  end

  // Output and weight-address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      first_term_q <= 1'b0;
      last_term_q  <= 1'b0;
      w_addr_q     <= '0;
    end else begin
      addr_valid_q <= addr_valid_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
      first_term_q <= first_term_d;
      last_term_q  <= last_term_d;
      w_addr_q     <= w_addr_d;
    end
  end

  assign alu_if.addr_valid = addr_valid_q;
  assign alu_if.in_addr    = in_addr_s;
  assign alu_if.w_addr     = w_addr_q;
  assign alu_if.neuron_idx = neuron_idx_s;
  assign alu_if.first_term = first_term_q;
  assign alu_if.last_term  = last_term_q;
  assign layer_done        = layer_done_q;
  assign busy              = busy_q;

endmodule

// File: doc/nn_address_generator.md
Name: nn_address_generator

Overview:
Address generator (AG) stage driven by the control unit's AG_rst/AG_read outputs. It walks a fully-connected layer: for each neuron it issues the input-vector address and the matching weight-memory address to the downstream MAC/ALU stage. It flags the first and last term of each neuron and signals completion of the layer. Addresses advance under a valid/ready handshake with the ALU.

Parameters:
N_INPUTS, 4, inputs per neuron (>=2)
N_NEURONS, 3, neurons in the layer (>=1)
IN_W, clog2(N_INPUTS), input address width (min 1)
N_W, clog2(N_NEURONS), neuron index width (min 1)
WA_W, clog2(N_INPUTS*N_NEURONS), weight address width (min 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
AG_rst  in  1  synchronous clear from control unit, active high
AG_read  in  1  run enable from control unit; low = pause
alu_ready  in  1  ALU accepts the current address this cycle
addr_valid  out  1  in_addr/w_addr valid for the ALU
in_addr  out  IN_W  input-vector address (0..N_INPUTS-1)
w_addr  out  WA_W  weight address = neuron_idx*N_INPUTS + in_addr
neuron_idx  out  N_W  current neuron
first_term  out  1  current address is input 0 of a neuron (ALU clears accumulator)
last_term  out  1  current address is input N_INPUTS-1 (ALU commits neuron result)
layer_done  out  1  one-cycle pulse when the final address has been accepted
busy  out  1  state == RUN

Behaviour:
- All outputs registered. Reset (reset=0, async): state IDLE, all counters 0, addr_valid=0, first_term=0, last_term=0, layer_done=0, busy=0.
- Priority: reset > AG_rst > handshake/advance.
- AG_rst=1 at a clock edge: from any state -> IDLE, counters 0, all flags 0, same values as async reset. Mid-layer AG_rst abandons the layer, with no layer_done.
- Transfer = addr_valid & alu_ready, sampled at the rising edge.
- States:
  - IDLE: AG_read=1 -> RUN. Next cycle addr_valid=1, in_addr=0, w_addr=0, neuron_idx=0, first_term=1. Latency 1 cycle from AG_read to first valid address.
  - RUN: on transfer, advance one term. in_addr wraps N_INPUTS-1 -> 0 and neuron_idx increments. w_addr is a free-running increment (no multiplier) and must equal neuron_idx*N_INPUTS+in_addr at all times.
    - addr_valid next = (next state RUN) & AG_read. AG_read low pauses: addresses hold and addr_valid drops the following cycle. A transfer in the cycle AG_read falls is still honoured. Resuming re-presents the held address, with no skip and no duplicate.
    - alu_ready=0 holds all address outputs stable while addr_valid=1.
    - Transfer on the last term of the last neuron -> DONE.
  - DONE: addr_valid=0, busy=0. layer_done=1 for exactly the first cycle in DONE. AG_read is ignored. Stays until AG_rst or reset.
- first_term and last_term are combinational functions of the registered in_addr, registered together with the address. With N_INPUTS>=2 they are never both high.
- N_NEURONS=1: neuron_idx stays 0 and DONE follows the N_INPUTS-th transfer.

Decomposition:
- Shared package nn_pkg: AG state encoding (IDLE/RUN/DONE), a clog2 helper function, and default layer dimensions shared with the control unit and ALU.
- One natural sub-module, nn_wrap_counter (enable, sync clear, wrap at MAX, terminal-count output). Instantiate it for in_addr and neuron_idx; w_addr is a plain incrementer in the parent.

Test Plan:
- Reset: hold reset=0 with AG_read=1 -> all outputs 0. Release reset -> first valid address (0,0) appears 1 cycle after AG_read is sampled.
- Full walk, N_INPUTS=3, N_NEURONS=2, alu_ready=1 -> w_addr 0,1,2,3,4,5; in_addr 0,1,2,0,1,2; neuron_idx 0,0,0,1,1,1. first_term at w_addr 0 and 3, last_term at 2 and 5. layer_done=1 for one cycle after w_addr=5 is accepted, then addr_valid=0.
- Backpressure: alu_ready=0 for 3 cycles at w_addr=2 -> outputs held at in_addr=2, last_term=1. On release, next is w_addr=3 with first_term=1.
- Pause: AG_read low for 2 cycles after w_addr=1 is accepted -> addr_valid=0 with address held at w_addr=2. AG_read high again -> w_addr=2 re-presented once, then continues.
- Mid-run AG_rst at w_addr=4 -> next cycle IDLE, all 0, no layer_done. Then AG_read=1 -> restart at w_addr=0.
- DONE persistence: AG_read kept high after layer_done -> addr_valid stays 0 and no second layer_done until AG_rst.
